// File: rtl/arp_ctrl.sv
// arp_ctrl: ARP receive capture, 4-entry IP->MAC cache, lookup and transmit control.
// Ports:
//   arp_rx_clk, rstn              clock, synchronous active-low reset
//   arp_rx_done/op, pc_mac/pc_ip  received ARP packet (pulse + sender fields)
//   lookup_req/ip                 cache lookup strobe and IP
//   lookup_valid/hit/mac          lookup result, one cycle after lookup_req
//   arp_tx_req/ack/done           transmit handshake
//   arp_tx_type/dst_mac/dst_ip    frame descriptor (1=request, 0=reply)
//   tx_timeout                    one-cycle pulse when a transmit is abandoned
//   drop_cnt                      saturating count of rx events lost to a busy slot
module arp_ctrl #(
    parameter logic [15:0] TX_TIMEOUT = 16'd50000
) (
    input  logic        arp_rx_clk,
    input  logic        rstn,
    input  logic        arp_rx_done,
    input  logic        arp_rx_op,
    input  logic [47:0] pc_mac,
    input  logic [31:0] pc_ip,
    input  logic        lookup_req,
    input  logic [31:0] lookup_ip,
    output logic        lookup_valid,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac,
    output logic        arp_tx_req,
    input  logic        arp_tx_ack,
    input  logic        arp_tx_done,
    output logic        arp_tx_type,
    output logic [47:0] arp_tx_dst_mac,
    output logic [31:0] arp_tx_dst_ip,
    output logic        tx_timeout,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [1:0] {IDLE, UPDATE, TX_REQ, TX_WAIT} state_t;
    state_t state_q, state_d;
    logic rx_pend_q, rx_pend_d, rx_op_q, rx_op_d, wk_op_q, wk_op_d;
    logic [47:0] rx_mac_q, rx_mac_d, wk_mac_q, wk_mac_d;
    logic [31:0] rx_ip_q, rx_ip_d, wk_ip_q, wk_ip_d;
    logic [7:0] drop_q, drop_d;
    logic [3:0] vld_q, vld_d;
    logic [3:0][31:0] cip_q, cip_d;
    logic [3:0][47:0] cmac_q, cmac_d;
    logic [1:0] ptr_q, ptr_d;
    logic lk_valid_q, lk_valid_d, lk_hit_q, lk_hit_d;
    logic [47:0] lk_mac_q, lk_mac_d;
    logic [31:0] lk_ip_q, lk_ip_d;
    logic miss_pend_q, miss_pend_d;
    logic [31:0] miss_ip_q, miss_ip_d;
    logic tx_type_q, tx_type_d, to_q, to_d;
    logic [47:0] tx_mac_q, tx_mac_d;
    logic [31:0] tx_ip_q, tx_ip_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic rx_take, upd_hit, upd_free;
    logic [1:0] upd_idx, free_idx, wr_idx;

    always_comb begin
        state_d     = state_q;
        rx_pend_d   = rx_pend_q;
        rx_op_d     = rx_op_q;
        rx_mac_d    = rx_mac_q;
        rx_ip_d     = rx_ip_q;
        wk_op_d     = wk_op_q;
        wk_mac_d    = wk_mac_q;
        wk_ip_d     = wk_ip_q;
        drop_d      = drop_q;
        vld_d       = vld_q;
        cip_d       = cip_q;
        cmac_d      = cmac_q;
        ptr_d       = ptr_q;
        miss_pend_d = miss_pend_q;
        miss_ip_d   = miss_ip_q;
        tx_type_d   = tx_type_q;
        tx_mac_d    = tx_mac_q;
        tx_ip_d     = tx_ip_q;
        to_cnt_d    = to_cnt_q;
        to_d        = 1'b0;
        lk_valid_d  = lookup_req;
        lk_hit_d    = 1'b0;
        lk_mac_d    = '0;
        lk_ip_d     = lookup_req ? lookup_ip : lk_ip_q;
        upd_hit     = 1'b0;
        upd_idx     = 2'd0;
        upd_free    = 1'b0;
        free_idx    = 2'd0;
        // Descending scans so the lowest matching/free index wins.
        for (int i = 3; i >= 0; i--) begin
            if (lookup_req && vld_q[i] && cip_q[i] == lookup_ip) begin
                lk_hit_d = 1'b1;
                lk_mac_d = cmac_q[i];
            end
            if (vld_q[i] && cip_q[i] == wk_ip_q) begin
                upd_hit = 1'b1;
                upd_idx = 2'(i);
            end
            if (!vld_q[i]) begin
                upd_free = 1'b1;
                free_idx = 2'(i);
            end
        end
        wr_idx  = upd_hit ? upd_idx : upd_free ? free_idx : ptr_q;
        // The slot is copied into the work registers as it is taken, so a
        // packet captured on that same cycle cannot corrupt the update.
        rx_take = state_q == IDLE && rx_pend_q;
        if (rx_take)
            rx_pend_d = 1'b0;
        if (arp_rx_done) begin
            if (rx_pend_q && !rx_take)
                drop_d = drop_q == 8'hFF ? drop_q : drop_q + 8'd1;
            else begin
                rx_pend_d = 1'b1;
                rx_op_d   = arp_rx_op;
                rx_mac_d  = pc_mac;
                rx_ip_d   = pc_ip;
            end
        end
        if (state_q == IDLE && !rx_pend_q && miss_pend_q)
            miss_pend_d = 1'b0;
        if (lk_valid_q && !lk_hit_q) begin
            miss_pend_d = 1'b1;
            miss_ip_d   = lk_ip_q;
        end
        case (state_q)
            IDLE: begin
                if (rx_pend_q) begin
                    state_d  = UPDATE;
                    wk_op_d  = rx_op_q;
                    wk_mac_d = rx_mac_q;
                    wk_ip_d  = rx_ip_q;
                end else if (miss_pend_q) begin
                    state_d   = TX_REQ;
                    tx_type_d = 1'b1;
                    tx_mac_d  = '1;
                    tx_ip_d   = miss_ip_q;
                end
            end
            UPDATE: begin
                vld_d[wr_idx]  = 1'b1;
                cip_d[wr_idx]  = wk_ip_q;
                cmac_d[wr_idx] = wk_mac_q;
                if (!upd_hit && !upd_free)
                    ptr_d = ptr_q + 2'd1;
                if (wk_op_q) begin
                    state_d   = TX_REQ;
                    tx_type_d = 1'b0;
                    tx_mac_d  = wk_mac_q;
                    tx_ip_d   = wk_ip_q;
                end else
                    state_d = IDLE;
            end
            TX_REQ: begin
                if (arp_tx_ack) begin
                    state_d  = TX_WAIT;
                    to_cnt_d = '0;
                end
            end
            TX_WAIT: begin
                if (arp_tx_done)
                    state_d = IDLE;
                else if (to_cnt_q == TX_TIMEOUT - 16'd1) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else
                    to_cnt_d = to_cnt_q + 16'd1;
            end
        endcase
    end

    always_ff @(posedge arp_rx_clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rx_pend_q   <= 1'b0;
            rx_op_q     <= 1'b0;
            rx_mac_q    <= '0;
            rx_ip_q     <= '0;
            wk_op_q     <= 1'b0;
            wk_mac_q    <= '0;
            wk_ip_q     <= '0;
            drop_q      <= '0;
            vld_q       <= '0;
            cip_q       <= '0;
            cmac_q      <= '0;
            ptr_q       <= '0;
            lk_valid_q  <= 1'b0;
            lk_hit_q    <= 1'b0;
            lk_mac_q    <= '0;
            lk_ip_q     <= '0;
            miss_pend_q <= 1'b0;
            miss_ip_q   <= '0;
            tx_type_q   <= 1'b0;
            tx_mac_q    <= '0;
            tx_ip_q     <= '0;
            to_cnt_q    <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_pend_q   <= rx_pend_d;
            rx_op_q     <= rx_op_d;
            rx_mac_q    <= rx_mac_d;
            rx_ip_q     <= rx_ip_d;
            wk_op_q     <= wk_op_d;
            wk_mac_q    <= wk_mac_d;
            wk_ip_q     <= wk_ip_d;
            drop_q      <= drop_d;
            vld_q       <= vld_d;
            cip_q       <= cip_d;
            cmac_q      <= cmac_d;
            ptr_q       <= ptr_d;
            lk_valid_q  <= lk_valid_d;
            lk_hit_q    <= lk_hit_d;
            lk_mac_q    <= lk_mac_d;
            lk_ip_q     <= lk_ip_d;
            miss_pend_q <= miss_pend_d;
            miss_ip_q   <= miss_ip_d;
            tx_type_q   <= tx_type_d;
            tx_mac_q    <= tx_mac_d;
            tx_ip_q     <= tx_ip_d;
            to_cnt_q    <= to_cnt_d;
            to_q        <= to_d;
        end
    end

    assign lookup_valid   = lk_valid_q;
    assign lookup_hit     = lk_hit_q;
    assign lookup_mac     = lk_mac_q;
    assign arp_tx_req     = state_q == TX_REQ;
    assign arp_tx_type    = tx_type_q;
    assign arp_tx_dst_mac = tx_mac_q;
    assign arp_tx_dst_ip  = tx_ip_q;
    assign tx_timeout     = to_q;
    assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_arp_ctrl.sv
// tb_arp_ctrl: directed self-checking bench for arp_ctrl (default and TX_TIMEOUT=8 instances).
module tb_arp_ctrl;
    logic        arp_rx_clk = 1'b0, rstn = 1'b0, arp_rx_done = 1'b0, arp_rx_op = 1'b0;
    logic        lookup_req = 1'b0, arp_tx_ack = 1'b0, arp_tx_done = 1'b0;
    logic [47:0] pc_mac = '0;
    logic [31:0] pc_ip = '0, lookup_ip = '0;
    logic        lookup_valid, lookup_hit, arp_tx_req, arp_tx_type, tx_timeout;
    logic [47:0] lookup_mac, arp_tx_dst_mac;
    logic [31:0] arp_tx_dst_ip;
    logic [7:0]  drop_cnt;
    logic        t_valid, t_hit, t_req, t_type, t_timeout;
    logic [47:0] t_mac, t_dst_mac;
    logic [31:0] t_dst_ip;
    logic [7:0]  t_drop;
    int vecs = 0, errs = 0;

    arp_ctrl dut (
        .arp_rx_clk(arp_rx_clk), .rstn(rstn), .arp_rx_done(arp_rx_done), .arp_rx_op(arp_rx_op),
        .pc_mac(pc_mac), .pc_ip(pc_ip), .lookup_req(lookup_req), .lookup_ip(lookup_ip),
        .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
        .arp_tx_req(arp_tx_req), .arp_tx_ack(arp_tx_ack), .arp_tx_done(arp_tx_done),
        .arp_tx_type(arp_tx_type), .arp_tx_dst_mac(arp_tx_dst_mac), .arp_tx_dst_ip(arp_tx_dst_ip),
        .tx_timeout(tx_timeout), .drop_cnt(drop_cnt)
    );

    arp_ctrl #(.TX_TIMEOUT(16'd8)) dut8 (
        .arp_rx_clk(arp_rx_clk), .rstn(rstn), .arp_rx_done(arp_rx_done), .arp_rx_op(arp_rx_op),
        .pc_mac(pc_mac), .pc_ip(pc_ip), .lookup_req(lookup_req), .lookup_ip(lookup_ip),
        .lookup_valid(t_valid), .lookup_hit(t_hit), .lookup_mac(t_mac),
        .arp_tx_req(t_req), .arp_tx_ack(arp_tx_ack), .arp_tx_done(arp_tx_done),
        .arp_tx_type(t_type), .arp_tx_dst_mac(t_dst_mac), .arp_tx_dst_ip(t_dst_ip),
        .tx_timeout(t_timeout), .drop_cnt(t_drop)
    );

    always #5 arp_rx_clk = ~arp_rx_clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge arp_rx_clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
    endtask

    task automatic rx(input logic op, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1;
        arp_rx_op = op;
        pc_mac = mac;
        pc_ip = ip;
        step();
        arp_rx_done = 1'b0;
    endtask

    task automatic serve;
        arp_tx_ack = 1'b1;
        step();
        arp_tx_ack = 1'b0;
        step();
        arp_tx_done = 1'b1;
        step();
        arp_tx_done = 1'b0;
        step();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (arp_tx_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac);
        bit ok;
        lookup_req = 1'b1;
        lookup_ip = ip;
        step();
        lookup_req = 1'b0;
        vecs++; if (lookup_valid !== 1'b1) begin errs++; $display("FAIL lk_valid ip=%h got %b want 1", ip, lookup_valid); end
        vecs++; if (lookup_hit !== hit) begin errs++; $display("FAIL lk_hit ip=%h got %b want %b", ip, lookup_hit, hit); end
        vecs++; if (lookup_mac !== (hit ? mac : 48'h0)) begin errs++; $display("FAIL lk_mac ip=%h got %h want %h", ip, lookup_mac, hit ? mac : 48'h0); end
        step();
        vecs++; if (lookup_valid !== 1'b0) begin errs++; $display("FAIL lk_valid_drop ip=%h got %b want 0", ip, lookup_valid); end
        if (!hit) begin
            wait_req(ok);
            vecs++; if (!ok) begin errs++; $display("FAIL miss_req ip=%h got no arp_tx_req want 1", ip); end
            vecs++; if (arp_tx_type !== 1'b1) begin errs++; $display("FAIL miss_type got %b want 1", arp_tx_type); end
            vecs++; if (arp_tx_dst_mac !== 48'hFFFF_FFFF_FFFF) begin errs++; $display("FAIL miss_dmac got %h want ffffffffffff", arp_tx_dst_mac); end
            vecs++; if (arp_tx_dst_ip !== ip) begin errs++; $display("FAIL miss_dip got %h want %h", arp_tx_dst_ip, ip); end
            serve();
        end
    endtask

    task automatic test_reset;
        do_reset();
        vecs++; if ({lookup_valid, lookup_hit, arp_tx_req, arp_tx_type, tx_timeout} !== 5'b0) begin errs++; $display("FAIL rst_bits got %b want 00000", {lookup_valid, lookup_hit, arp_tx_req, arp_tx_type, tx_timeout}); end
        vecs++; if (lookup_mac !== 48'h0 || arp_tx_dst_mac !== 48'h0) begin errs++; $display("FAIL rst_macs got %h/%h want 0", lookup_mac, arp_tx_dst_mac); end
        vecs++; if (arp_tx_dst_ip !== 32'h0 || drop_cnt !== 8'h0) begin errs++; $display("FAIL rst_ip_drop got %h/%h want 0", arp_tx_dst_ip, drop_cnt); end
    endtask

    task automatic test_rx_request;
        rx(1'b1, 48'h0011_22AA_BBCC, 32'hC0A8_0002);
        vecs++; if (arp_tx_req !== 1'b0) begin errs++; $display("FAIL req_capture got %b want 0", arp_tx_req); end
        step();
        vecs++; if (arp_tx_req !== 1'b0) begin errs++; $display("FAIL req_update got %b want 0", arp_tx_req); end
        step();
        vecs++; if (arp_tx_req !== 1'b1) begin errs++; $display("FAIL req_txreq got %b want 1", arp_tx_req); end
        vecs++; if (arp_tx_type !== 1'b0) begin errs++; $display("FAIL req_type got %b want 0", arp_tx_type); end
        vecs++; if (arp_tx_dst_mac !== 48'h0011_22AA_BBCC) begin errs++; $display("FAIL req_dmac got %h want 001122aabbcc", arp_tx_dst_mac); end
        vecs++; if (arp_tx_dst_ip !== 32'hC0A8_0002) begin errs++; $display("FAIL req_dip got %h want c0a80002", arp_tx_dst_ip); end
        step();
        vecs++; if (arp_tx_req !== 1'b1) begin errs++; $display("FAIL req_hold got %b want 1", arp_tx_req); end
        arp_tx_ack = 1'b1;
        step();
        arp_tx_ack = 1'b0;
        vecs++; if (arp_tx_req !== 1'b0) begin errs++; $display("FAIL req_ack got %b want 0", arp_tx_req); end
        step(3);
        vecs++; if (arp_tx_req !== 1'b0 || arp_tx_dst_ip !== 32'hC0A8_0002) begin errs++; $display("FAIL req_wait got %b/%h want 0/c0a80002", arp_tx_req, arp_tx_dst_ip); end
        arp_tx_done = 1'b1;
        step();
        arp_tx_done = 1'b0;
        vecs++; if (tx_timeout !== 1'b0) begin errs++; $display("FAIL req_done_to got %b want 0", tx_timeout); end
    endtask

    task automatic test_lookup;
        do_lookup(32'hC0A8_0002, 1'b1, 48'h0011_22AA_BBCC);
        do_lookup(32'hC0A8_0009, 1'b0, 48'h0);
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset();
        rx(1'b0, 48'hAAAA_0000_0001, 32'h0B00_0001);
        rx(1'b0, 48'hAAAA_0000_0002, 32'h0B00_0002);
        step(3);
        vecs++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL b2b_drop got %0d want 0", drop_cnt); end
        do_lookup(32'h0B00_0001, 1'b1, 48'hAAAA_0000_0001);
        do_lookup(32'h0B00_0002, 1'b1, 48'hAAAA_0000_0002);
        rx(1'b0, 48'hAAAA_0000_0003, 32'h0B00_0003);
        step();
        lookup_req = 1'b1;
        lookup_ip = 32'h0B00_0003;
        step();
        lookup_req = 1'b0;
        vecs++; if (lookup_valid !== 1'b1 || lookup_hit !== 1'b0) begin errs++; $display("FAIL samecyc_write got v%b h%b want v1 h0", lookup_valid, lookup_hit); end
        wait_req(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL samecyc_miss_req got none want req"); end
        serve();
        do_lookup(32'h0B00_0003, 1'b1, 48'hAAAA_0000_0003);
    endtask

    task automatic test_cache_fill;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            rx(1'b0, 48'hA000_0000_0000 + 48'(i), 32'h0A00_0000 + 32'(i));
            step(2);
        end
        do_lookup(32'h0A00_0001, 1'b0, 48'h0);
        do_lookup(32'h0A00_0005, 1'b1, 48'hA000_0000_0005);
        do_lookup(32'h0A00_0002, 1'b1, 48'hA000_0000_0002);
        do_lookup(32'h0A00_0004, 1'b1, 48'hA000_0000_0004);
        rx(1'b0, 48'hB000_0000_0003, 32'h0A00_0003);
        step(2);
        do_lookup(32'h0A00_0003, 1'b1, 48'hB000_0000_0003);
        rx(1'b0, 48'hA000_0000_0006, 32'h0A00_0006);
        step(2);
        do_lookup(32'h0A00_0002, 1'b0, 48'h0);
        do_lookup(32'h0A00_0003, 1'b1, 48'hB000_0000_0003);
        do_lookup(32'h0A00_0006, 1'b1, 48'hA000_0000_0006);
        do_lookup(32'h0A00_0004, 1'b1, 48'hA000_0000_0004);
    endtask

    task automatic test_drop;
        do_reset();
        rx(1'b1, 48'hC000_0000_0001, 32'h0C00_0001);
        step(2);
        arp_tx_ack = 1'b1;
        step();
        arp_tx_ack = 1'b0;
        arp_rx_done = 1'b1;
        arp_rx_op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_mac = 48'hD000_0000_0000 + 48'(i);
            pc_ip = 32'h0D00_0000 + 32'(i);
            step();
        end
        arp_rx_done = 1'b0;
        vecs++; if (drop_cnt !== 8'd2) begin errs++; $display("FAIL drop_two got %0d want 2", drop_cnt); end
        arp_rx_done = 1'b1;
        pc_mac = 48'hEEEE_EEEE_EEEE;
        pc_ip = 32'h0E0E_0E0E;
        step(300);
        arp_rx_done = 1'b0;
        vecs++; if (drop_cnt !== 8'd255) begin errs++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
        arp_tx_done = 1'b1;
        step();
        arp_tx_done = 1'b0;
        step(3);
        do_lookup(32'h0D00_0000, 1'b1, 48'hD000_0000_0000);
        do_lookup(32'h0C00_0001, 1'b1, 48'hC000_0000_0001);
        vecs++; if (drop_cnt !== 8'd255) begin errs++; $display("FAIL drop_hold got %0d want 255", drop_cnt); end
    endtask

    task automatic test_timeout;
        do_reset();
        rx(1'b1, 48'hF000_0000_0001, 32'h0F00_0001);
        step(2);
        vecs++; if (t_req !== 1'b1) begin errs++; $display("FAIL to_req got %b want 1", t_req); end
        arp_tx_ack = 1'b1;
        step();
        arp_tx_ack = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            vecs++; if (t_timeout !== 1'b0) begin errs++; $display("FAIL to_early k=%0d got %b want 0", k, t_timeout); end
        end
        step();
        vecs++; if (t_timeout !== 1'b1) begin errs++; $display("FAIL to_pulse got %b want 1", t_timeout); end
        step();
        vecs++; if (t_timeout !== 1'b0) begin errs++; $display("FAIL to_once got %b want 0", t_timeout); end
        rx(1'b1, 48'hF000_0000_0002, 32'h0F00_0002);
        step(2);
        vecs++; if (t_req !== 1'b1 || t_dst_ip !== 32'h0F00_0002) begin errs++; $display("FAIL to_idle got %b/%h want 1/0f000002", t_req, t_dst_ip); end
        arp_tx_ack = 1'b1;
        step();
        arp_tx_ack = 1'b0;
        step(7);
        arp_tx_done = 1'b1;
        step();
        arp_tx_done = 1'b0;
        vecs++; if (t_timeout !== 1'b0) begin errs++; $display("FAIL to_donewins got %b want 0", t_timeout); end
        step();
        vecs++; if (t_timeout !== 1'b0 || t_req !== 1'b0) begin errs++; $display("FAIL to_after got %b/%b want 0/0", t_timeout, t_req); end
    endtask

    task automatic test_reset_mid_tx;
        do_reset();
        rx(1'b1, 48'h1234_5678_9ABC, 32'h0A0A_0A01);
        step(2);
        vecs++; if (arp_tx_req !== 1'b1) begin errs++; $display("FAIL mid_req got %b want 1", arp_tx_req); end
        rx(1'b1, 48'h1234_5678_9ABD, 32'h0A0A_0A02);
        rstn = 1'b0;
        step();
        vecs++; if (arp_tx_req !== 1'b0 || t_req !== 1'b0) begin errs++; $display("FAIL mid_rst_req got %b/%b want 0/0", arp_tx_req, t_req); end
        vecs++; if (arp_tx_dst_ip !== 32'h0 || arp_tx_dst_mac !== 48'h0) begin errs++; $display("FAIL mid_rst_dst got %h/%h want 0", arp_tx_dst_ip, arp_tx_dst_mac); end
        rstn = 1'b1;
        step(5);
        vecs++; if (arp_tx_req !== 1'b0) begin errs++; $display("FAIL mid_pend_discard got %b want 0", arp_tx_req); end
        do_lookup(32'h0A0A_0A01, 1'b0, 48'h0);
    endtask

    initial begin
        test_reset();
        test_rx_request();
        test_lookup();
        test_back_to_back();
        test_cache_fill();
        test_drop();
        test_timeout();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/arp_ctrl.md
ARP_CTRL -- requirements
Module: arp_ctrl

Interface
REQ-001 SHALL have parameter TX_TIMEOUT, default 16'd50000: max cycles to wait for arp_tx_done after ack.
REQ-002 SHALL have port arp_rx_clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port arp_rx_done  input  1  one-cycle pulse; a valid ARP packet was received.
REQ-005 SHALL have port arp_rx_op  input  1  1=request, 0=reply; sampled with arp_rx_done.
REQ-006 SHALL have port pc_mac  input  48  sender MAC; sampled with arp_rx_done.
REQ-007 SHALL have port pc_ip  input  32  sender IP; sampled with arp_rx_done.
REQ-008 SHALL have port lookup_req  input  1  one-cycle lookup strobe.
REQ-009 SHALL have port lookup_ip  input  32  IP to resolve; sampled with lookup_req.
REQ-010 SHALL have port lookup_valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port lookup_hit  output  1  1=entry found; qualified by lookup_valid.
REQ-012 SHALL have port lookup_mac  output  48  resolved MAC; 0 on miss.
REQ-013 SHALL have port arp_tx_req  output  1  transmit request; level, held until ack.
REQ-014 SHALL have port arp_tx_ack  input  1  transmitter accepted the request.
REQ-015 SHALL have port arp_tx_done  input  1  transmitter finished the frame.
REQ-016 SHALL have port arp_tx_type  output  1  1=request, 0=reply.
REQ-017 SHALL have port arp_tx_dst_mac  output  48  destination MAC for the frame.
REQ-018 SHALL have port arp_tx_dst_ip  output  32  destination IP for the frame.
REQ-019 SHALL have port tx_timeout  output  1  one-cycle pulse on transmit abort.
REQ-020 SHALL have port drop_cnt  output  8  saturating count of dropped rx events.

Function
REQ-021 Rx capture: on arp_rx_done, latch op/mac/ip into a single pending slot and set rx_pend.
REQ-022 Done while rx_pend set and not cleared that cycle: event dropped, drop_cnt += 1, saturating at 255; done on the same cycle rx_pend clears: captured (set wins).
REQ-023 Cache: 4 entries {valid, ip[31:0], mac[47:0]}, all invalid after reset.
REQ-024 Cache write (UPDATE state): IP matches a valid entry -> overwrite its MAC; else lowest-index invalid entry; else entry at 2-bit round-robin pointer, pointer += 1 wrapping 3->0.
REQ-025 Lookup: lookup_valid asserts exactly 1 cycle after lookup_req; lookup_hit/lookup_mac reflect cache contents on the lookup_req cycle (a same-cycle write is not visible).
REQ-026 Miss: on the cycle lookup_valid asserts with lookup_hit=0, set miss_pend and latch miss_ip=lookup_ip; a new miss while miss_pend set overwrites miss_ip (latest wins).
REQ-027 FSM states: IDLE, UPDATE, TX_REQ, TX_WAIT.
REQ-028 IDLE: rx_pend -> UPDATE (clears rx_pend); else miss_pend -> TX_REQ as request (clears miss_pend); rx has priority.
REQ-029 UPDATE: exactly one cycle; write cache; op=request -> TX_REQ as reply; op=reply -> IDLE.
REQ-030 On TX_REQ entry, load tx registers: reply -> type 0, dst = latched pc_mac/pc_ip; request -> type 1, dst_mac 48'hFF_FF_FF_FF_FF_FF, dst_ip = miss_ip; values stable until return to IDLE.
REQ-031 TX_REQ: arp_tx_req=1 until arp_tx_ack sampled high; next cycle arp_tx_req=0, state TX_WAIT, timeout counter cleared.
REQ-032 TX_WAIT: arp_tx_done -> IDLE; counter reaching TX_TIMEOUT-1 without done -> IDLE with tx_timeout=1 for one cycle; done and terminal count same cycle: done wins, no pulse.
REQ-033 Rx capture, drop counting and lookups SHALL continue in every FSM state.

Reset
REQ-034 rstn=0 SHALL force: state IDLE, cache invalid, pointer 0, rx_pend=0, miss_pend=0, counters 0, all outputs 0.
REQ-035 Reset mid-transmit SHALL drop arp_tx_req the next edge and discard pending work.

Verification
REQ-036 Rx request done (op=1, mac=0x001122AABBCC, ip=0xC0A80002) -> UPDATE, then arp_tx_req=1 with type 0, dst mac/ip as given; ack -> req=0; done -> IDLE.
REQ-037 Lookup 0xC0A80002 after REQ-036 -> next cycle lookup_valid=1, hit=1, mac=0x001122AABBCC; lookup 0xC0A80009 -> hit=0, then request with dst_mac all-ones, dst_ip 0xC0A80009.
REQ-038 Five replies with distinct IPs -> entries 0..3 filled, fifth overwrites entry 0, pointer=1; reply with existing IP -> MAC updated in place, pointer unchanged.
REQ-039 Three rx_done pulses during TX_WAIT -> first captured, two dropped, drop_cnt=2; 300 extra drops -> drop_cnt=255.
REQ-040 TX_TIMEOUT=8, ack but no done -> tx_timeout pulses once 8 cycles after TX_WAIT entry, state IDLE; rstn=0 during TX_REQ -> arp_tx_req=0 next cycle, cache invalid.
